// File: rtl/tdm_scan_ctrl.sv
// Two-channel TDM scanner: steps a 2:1 mux between B and A, samples y_in after a settle delay
// and latches each channel. Optional 2-of-3 vote per channel under `TDM_SCAN_MAJORITY_EN.
module tdm_scan_ctrl #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       select,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       a_valid,
  output logic       b_valid,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN_B = 2'd1, SCAN_A = 2'd2} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);
  localparam logic [7:0] SAMP = 8'(SETTLE);

  if (DWELL < 2 || DWELL > 255 || SETTLE < 0 || SETTLE > DWELL - 1) begin : g_bad_params
    $error("tdm_scan_ctrl: DWELL must be 2..255 and SETTLE 0..DWELL-1");
  end

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       term;
  logic       scanning;
  logic       latch_en;
  logic       latch_val;

  // Pulse semantics: a_valid/b_valid/frame_done are high for exactly one cycle and are
  // never back-pressured; a_valid and b_valid are exclusive because they depend on state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    term      = (cnt == LAST);
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SCAN_B;
          cnt_nxt   = 8'd0;
        end
      end
      SCAN_B: begin
        if (term) begin
          state_nxt = SCAN_A;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SCAN_A: begin
        if (term) begin
          state_nxt = enable ? SCAN_B : IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign scanning  = (state == SCAN_B) || (state == SCAN_A);
  assign select    = (state == SCAN_A);
  assign dbg_state = state;

`ifdef TDM_SCAN_MAJORITY_EN
  if (SETTLE + 2 > DWELL - 1) begin : g_bad_vote_window
    $error("tdm_scan_ctrl: majority vote needs SETTLE+2 <= DWELL-1");
  end

  logic samp0, samp1;

  // The first two votes are held; the third is taken live from y_in on the latch edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp0 <= 1'b0;
      samp1 <= 1'b0;
    end else if (scanning) begin
      if (cnt == SAMP)         samp0 <= y_in;
      if (cnt == SAMP + 8'd1)  samp1 <= y_in;
    end
  end

  assign latch_en  = scanning && (cnt == SAMP + 8'd2);
  assign latch_val = (samp0 & samp1) | (samp0 & y_in) | (samp1 & y_in);
`else
  assign latch_en  = scanning && (cnt == SAMP);
  assign latch_val = y_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      frame_done <= (state == SCAN_A) && term;
      if (latch_en) begin
        if (state == SCAN_A) begin
          a_out   <= latch_val;
          a_valid <= 1'b1;
        end else begin
          b_out   <= latch_val;
          b_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tdm_scan_ctrl.md
TDM_SCAN_CTRL -- requirements
Module: tdm_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning clock cycles spent on each channel; legal range 2..255.
REQ-002 SHALL have parameter SETTLE, default 1, meaning cycles after a channel switch before y_in is sampled; legal range 0..DWELL-1.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  requests continuous scanning.
REQ-006 SHALL have port select  output  1  drives the 2:1 mux select; 0 routes B, 1 routes A.
REQ-007 SHALL have port y_in  input  1  mux output being demultiplexed.
REQ-008 SHALL have ports a_out and b_out  output  1 each  latched channel values.
REQ-009 SHALL have ports a_valid and b_valid  output  1 each  one-cycle pulse when the matching *_out updates.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at the end of each B+A frame.

Function
REQ-011 SHALL implement an FSM with states IDLE, SCAN_B and SCAN_A, plus a dwell counter cnt of 8 bits.
REQ-012 SHALL decode select from the registered state: IDLE->0, SCAN_B->0, SCAN_A->1.
REQ-013 SHALL move IDLE->SCAN_B with cnt=0 on the first edge that sees enable=1.
REQ-014 SHALL increment cnt each cycle in SCAN_B/SCAN_A; at cnt==DWELL-1 it SHALL clear cnt and switch channel.
REQ-015 SHALL switch SCAN_B->SCAN_A unconditionally.
REQ-016 SHALL switch SCAN_A->SCAN_B if enable=1 at that edge, else SCAN_A->IDLE.
REQ-017 SHALL ignore enable deassertion mid-frame; the current frame completes.
REQ-018 SHALL sample y_in at the edge where cnt==SETTLE; the value SHALL appear on b_out (SCAN_B) or a_out (SCAN_A) the next cycle, with b_valid/a_valid high for exactly that cycle.
REQ-019 SHALL pulse frame_done for one cycle starting the cycle after the SCAN_A terminal edge (cnt==DWELL-1), whether the next state is SCAN_B or IDLE.
REQ-020 SHALL hold a_out/b_out between updates and while in IDLE.
REQ-021 SHALL give a frame period of exactly 2*DWELL cycles with no idle gap between back-to-back frames.
REQ-022 SHALL never assert a_valid and b_valid in the same cycle.

Reset
REQ-023 SHALL, on a rst=1 edge, set state=IDLE, cnt=0, select=0, a_out=0, b_out=0, and set a_valid, b_valid and frame_done to 0.
REQ-024 SHALL let rst override enable and any in-progress frame; no valid or frame_done pulse follows a mid-frame reset.
REQ-025 SHALL resume with SCAN_B from cnt=0 after rst falls if enable=1.

Configuration
REQ-026 SHALL, with macro TDM_SCAN_MAJORITY_EN defined, sample y_in at cnt==SETTLE, SETTLE+1 and SETTLE+2, and latch the 2-of-3 majority one cycle after the third sample, with the valid pulse moved accordingly.
REQ-027 SHALL, with TDM_SCAN_MAJORITY_EN defined, require SETTLE+2 <= DWELL-1, enforced by an elaboration-time error.
REQ-028 SHALL, without TDM_SCAN_MAJORITY_EN, use the single-sample behaviour of REQ-018 and contain no vote logic.

Verification
REQ-029 SHALL cover: DWELL=4, SETTLE=1, enable held 1, y_in driven as mux of A=1,B=0 -> select 0,0,0,0,1,1,1,1 repeating; b_out=0 with b_valid at cycle 2 after start; a_out=1 with a_valid at cycle 6; frame_done at cycle 8.
REQ-030 SHALL cover: enable dropped during SCAN_B cycle 1 -> frame completes, one frame_done, then select=0 and state IDLE; no further valid pulses.
REQ-031 SHALL cover: rst=1 at SCAN_A cnt=2 with a_out previously 1 -> next cycle all outputs 0, no a_valid or frame_done; scan restarts at SCAN_B on release.
REQ-032 SHALL cover: DWELL=2, SETTLE=0 -> select toggles every 2 cycles, frame_done every 4 cycles, valids alternate b/a.
REQ-033 SHALL cover: TDM_SCAN_MAJORITY_EN defined, B-channel y_in samples 1,0,1 -> b_out=1; samples 0,1,0 -> b_out=0; b_valid one cycle after the third sample.
REQ-034 SHALL cover: enable and rst both 1 on the same edge -> state stays IDLE and select=0.
